id_stage: RTL

//  Decode stage of the 5-stage RV32I pipeline, between the IF/ID register and EX.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/id_stage_imm_gen.sv | 33 +++
 rtl/id_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I pipeline: base opcodes, immediate
// format selector and the 4-bit ALU operation codes ({funct7[5], funct3}).
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // OP-IMM only carries funct7[5] for the shift-right pair (SRLI/SRAI);
  // elsewhere bit 30 is immediate data and must not turn ADDI into SUB.
  function automatic logic [3:0] alu_op_imm(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    return {(f3 == 3'b101) & instr[30], f3};
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// imm_gen: combinational immediate generator.
//   i_instr    : 32-bit instruction word
//   i_imm_type : immediate format (I/S/B/U/J, or NONE -> 0)
//   o_imm      : sign-extended XLEN-bit immediate
module imm_gen
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  imm_type_e       i_imm_type,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (i_imm_type)
      IMM_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: w_imm32 = {i_instr[31:12], 12'b0};
      IMM_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage and ID/EX pipeline register.
//   clk, rst_n            : clock, async active-low reset
//   if_valid/instr/pc     : IF/ID input op;  if_ready : ID accepts this cycle
//   rf_rs1/2_adr          : RF read addresses (combinational from if_instr)
//   rf_rs1/2_dt           : RF read data, sampled with the instruction
//   ex_ready, ex_flush    : EX back-pressure and taken-branch kill
//   idex_*                : registered decoded op presented to EX
module id_stage
  import cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int HAZ_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  output logic [4:0]      rf_rs1_adr,
  output logic [4:0]      rf_rs2_adr,
  input  logic [XLEN-1:0] rf_rs1_dt,
  input  logic [XLEN-1:0] rf_rs2_dt,
  input  logic            ex_ready,
  input  logic            ex_flush,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [XLEN-1:0] idex_rs1_dt,
  output logic [XLEN-1:0] idex_rs2_dt,
  output logic [4:0]      idex_rs1,
  output logic [4:0]      idex_rs2,
  output logic [4:0]      idex_rd,
  output logic [XLEN-1:0] idex_imm,
  output logic [3:0]      idex_alu_op,
  output logic            idex_alusrc,
  output logic            idex_regwr,
  output logic            idex_memrd,
  output logic            idex_memwr,
  output logic            idex_branch,
  output logic            idex_illegal
);

  localparam logic HAZ_ON = (HAZ_EN != 0);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  imm_type_e       w_imm_type;
  logic [XLEN-1:0] w_imm;
  logic [3:0]      w_alu_op;
  logic            w_alusrc, w_regwr, w_memrd, w_memwr, w_branch, w_illegal;
  logic            w_uses_rs1, w_uses_rs2;
  logic            w_hazard, w_hold;

  logic            r_valid;
  logic [XLEN-1:0] r_pc, r_rs1_dt, r_rs2_dt, r_imm;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [3:0]      r_alu_op;
  logic            r_alusrc, r_regwr, r_memrd, r_memwr, r_branch, r_illegal;

  assign w_opcode   = if_instr[6:0];
  assign w_rd       = if_instr[11:7];
  assign w_rs1      = if_instr[19:15];
  assign w_rs2      = if_instr[24:20];
  assign rf_rs1_adr = w_rs1;
  assign rf_rs2_adr = w_rs2;

  always_comb begin
    w_imm_type = IMM_NONE;
    w_alu_op   = ALU_ADD;
    w_alusrc   = 1'b0;
    w_regwr    = 1'b0;
    w_memrd    = 1'b0;
    w_memwr    = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_alu_op   = {if_instr[30], if_instr[14:12]};
        w_regwr    = 1'b1;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_I: begin
        w_imm_type = IMM_I;
        w_alu_op   = alu_op_imm(if_instr);
        w_alusrc   = 1'b1;
        w_regwr    = 1'b1;
        w_uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        w_imm_type = IMM_I;
        w_alusrc   = 1'b1;
        w_regwr    = 1'b1;
        w_memrd    = 1'b1;
        w_uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        w_imm_type = IMM_S;
        w_alusrc   = 1'b1;
        w_memwr    = 1'b1;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        // Compare selected by funct3; bit 30 is immediate data here.
        w_imm_type = IMM_B;
        w_alu_op   = {1'b0, if_instr[14:12]};
        w_branch   = 1'b1;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        w_imm_type = IMM_J;
        w_alusrc   = 1'b1;
        w_regwr    = 1'b1;
        w_branch   = 1'b1;
      end
      OP_JALR: begin
        w_imm_type = IMM_I;
        w_alusrc   = 1'b1;
        w_regwr    = 1'b1;
        w_branch   = 1'b1;
        w_uses_rs1 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm_type = IMM_U;
        w_alusrc   = 1'b1;
        w_regwr    = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_rd == 5'd0) w_regwr = 1'b0;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr    (if_instr),
    .i_imm_type (w_imm_type),
    .o_imm      (w_imm)
  );

  // Load in ID/EX whose result is needed by the op now in IF/ID.
  assign w_hazard = HAZ_ON & if_valid & r_valid & r_memrd & (r_rd != 5'd0) &
                    ((w_uses_rs1 & (w_rs1 == r_rd)) | (w_uses_rs2 & (w_rs2 == r_rd)));
  assign w_hold   = ~ex_ready & r_valid;
  assign if_ready = ex_flush | (~w_hold & ~w_hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rs1_dt  <= '0;
      r_rs2_dt  <= '0;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_alu_op  <= '0;
      r_alusrc  <= 1'b0;
      r_regwr   <= 1'b0;
      r_memrd   <= 1'b0;
      r_memwr   <= 1'b0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (ex_flush || (!w_hold && w_hazard)) begin
      // Flush overrides any hold; both flush and bubble empty the slot.
      r_valid   <= 1'b0;
      r_alusrc  <= 1'b0;
      r_regwr   <= 1'b0;
      r_memrd   <= 1'b0;
      r_memwr   <= 1'b0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (!w_hold) begin
      r_valid   <= if_valid;
      r_pc      <= if_pc;
      r_rs1_dt  <= rf_rs1_dt;
      r_rs2_dt  <= rf_rs2_dt;
      r_imm     <= w_imm;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_rd      <= w_rd;
      r_alu_op  <= w_alu_op;
      r_alusrc  <= w_alusrc  & if_valid;
      r_regwr   <= w_regwr   & if_valid;
      r_memrd   <= w_memrd   & if_valid;
      r_memwr   <= w_memwr   & if_valid;
      r_branch  <= w_branch  & if_valid;
      r_illegal <= w_illegal & if_valid;
    end
  end

  assign idex_valid   = r_valid;
  assign idex_pc      = r_pc;
  assign idex_rs1_dt  = r_rs1_dt;
  assign idex_rs2_dt  = r_rs2_dt;
  assign idex_rs1     = r_rs1;
  assign idex_rs2     = r_rs2;
  assign idex_rd      = r_rd;
  assign idex_imm     = r_imm;
  assign idex_alu_op  = r_alu_op;
  assign idex_alusrc  = r_alusrc;
  assign idex_regwr   = r_regwr;
  assign idex_memrd   = r_memrd;
  assign idex_memwr   = r_memwr;
  assign idex_branch  = r_branch;
  assign idex_illegal = r_illegal;

endmodule
